// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - shared types and defaults for the pair scheduler
package md_sched_pkg;

  localparam int NUM_FILTER_DEF        = 7;
  localparam int PARTICLE_ID_WIDTH_DEF = 7;
  localparam int RD_LATENCY_DEF        = 2;

  typedef enum logic [2:0] {
    IDLE,
    PH_INIT,
    REF_RD,
    REF_WAIT,
    STREAM,
    FLUSH,
    DRAIN,
    NEXT
  } sched_state_t;

  typedef logic [PARTICLE_ID_WIDTH_DEF:0]   count_t;
  typedef logic [PARTICLE_ID_WIDTH_DEF-1:0] pid_t;

endpackage

// File: rtl/pair_sched_delay.sv
// rtl/pair_sched_delay.sv - fixed-depth shift register with asynchronous clear
module pair_sched_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/pair_scheduler.sv
// rtl/pair_scheduler.sv - sequences reference/neighbour reads for one force-evaluation pass
module pair_scheduler
  import md_sched_pkg::*;
#(
  parameter int NUM_FILTER        = NUM_FILTER_DEF,
  parameter int PARTICLE_ID_WIDTH = PARTICLE_ID_WIDTH_DEF,
  parameter int RD_LATENCY        = RD_LATENCY_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [PARTICLE_ID_WIDTH:0]                  ref_count,
  input  logic [NUM_FILTER-1:0][PARTICLE_ID_WIDTH:0]  nb_count,
  input  logic [NUM_FILTER-1:0]                       back_pressure,
  input  logic                                        all_buffer_empty,
  output logic                                        phase,
  output logic                                        ref_rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0]                ref_rd_addr,
  output logic                                        ref_load,
  output logic                                        nb_rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0]                nb_rd_addr,
  output logic [NUM_FILTER-1:0]                       input_valid,
  output logic [PARTICLE_ID_WIDTH-1:0]                nb_id_in,
  output logic                                        busy,
  output logic                                        done
);

  localparam int CW = PARTICLE_ID_WIDTH + 1;
  localparam int DW = NUM_FILTER + PARTICLE_ID_WIDTH;

  sched_state_t state, state_nxt;

  logic [CW-1:0]                 cnt_ref, nb_max, r, n, nb_max_in;
  logic [NUM_FILTER-1:0][CW-1:0] cnt_nb;
  logic [2:0]                    wait_cnt;
  logic                          phase_q;
  logic [NUM_FILTER-1:0]         en;
  logic                          issue, last_issue, more_ref, wait_done, flush_done;
  logic [DW-1:0]                 dl_in, dl_out;

  always_comb begin
    nb_max_in = '0;
    for (int k = 0; k < NUM_FILTER; k++)
      if (nb_count[k] > nb_max_in) nb_max_in = nb_count[k];
  end

  // Filter 0 is the home cell: phase 0 only pairs with higher ids (half shell).
  always_comb begin
    en = '0;
    for (int k = 0; k < NUM_FILTER; k++) en[k] = (n < cnt_nb[k]);
    en[0] = (n < cnt_nb[0]) && (phase_q || (n > r));
  end

  assign issue      = (state == STREAM) && (back_pressure == '0);
  assign last_issue = issue && ((n + CW'(1)) == nb_max);
  assign more_ref   = (r + CW'(1)) < cnt_ref;
  assign wait_done  = (wait_cnt == 3'(RD_LATENCY - 1));
  assign flush_done = (wait_cnt == 3'(RD_LATENCY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = PH_INIT;
      PH_INIT:  state_nxt = (ref_count == '0) ? NEXT : REF_RD;
      REF_RD:   state_nxt = REF_WAIT;
      REF_WAIT: if (wait_done) state_nxt = (nb_max == '0) ? FLUSH : STREAM;
      STREAM:   if (last_issue) state_nxt = FLUSH;
      FLUSH:    if (flush_done) state_nxt = DRAIN;
      DRAIN:    if (all_buffer_empty) state_nxt = NEXT;
      NEXT: begin
        if (more_ref)      state_nxt = REF_RD;
        else if (!phase_q) state_nxt = PH_INIT;
        else begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_ref  <= '0;
      cnt_nb   <= '0;
      nb_max   <= '0;
      r        <= '0;
      n        <= '0;
      wait_cnt <= '0;
      phase_q  <= 1'b0;
    end else begin
      wait_cnt <= (state_nxt == state) ? wait_cnt + 3'd1 : 3'd0;
      case (state)
        IDLE:     if (start) phase_q <= 1'b0;
        PH_INIT: begin
          cnt_ref <= ref_count;
          cnt_nb  <= nb_count;
          nb_max  <= nb_max_in;
          r       <= '0;
        end
        REF_WAIT: n <= '0;
        STREAM:   if (issue) n <= n + CW'(1);
        NEXT: begin
          if (more_ref)      r <= r + CW'(1);
          else if (!phase_q) phase_q <= 1'b1;
          else               phase_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign phase       = phase_q;
  assign busy        = (state != IDLE);
  assign ref_rd_en   = (state == REF_RD);
  assign ref_rd_addr = ref_rd_en ? r[PARTICLE_ID_WIDTH-1:0] : '0;
  assign nb_rd_en    = issue;
  assign nb_rd_addr  = issue ? n[PARTICLE_ID_WIDTH-1:0] : '0;
  assign dl_in       = issue ? {en, n[PARTICLE_ID_WIDTH-1:0]} : '0;

  pair_sched_delay #(.WIDTH(DW), .DEPTH(RD_LATENCY)) u_pair_delay (
    .clk  (clk),
    .rst_n(rst),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign input_valid = dl_out[DW-1:PARTICLE_ID_WIDTH];
  assign nb_id_in    = dl_out[PARTICLE_ID_WIDTH-1:0];

  pair_sched_delay #(.WIDTH(1), .DEPTH(RD_LATENCY)) u_ref_delay (
    .clk  (clk),
    .rst_n(rst),
    .din  (ref_rd_en),
    .dout (ref_load)
  );

endmodule
